// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for one requester of the shared ALU.
// The master side is the requester, the slave side is the arbiter.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output valid, aluop, funct, a, b, rsp_ready,
    input  ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  valid, aluop, funct, a, b, rsp_ready,
    output ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between the EX stage (r0) and the
// address-gen/branch unit (r1); one transaction in flight, registered response.
module alu_share_arbiter #(
  parameter int WIDTH     = 32,
  parameter bit FIRST_PRI = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_share_arbiter_if.slave r0,
  alu_share_arbiter_if.slave r1,
  output logic              alu_en,
  output logic [2:0]        alu_ctl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             rr_q;
  logic             port_q;
  logic             illegal_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_ctl_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;

  logic             gnt0, gnt1, in_idle, hs;
  logic [1:0]       sel_aluop;
  logic [5:0]       sel_funct;
  logic [2:0]       dec_ctl;
  logic             dec_illegal;
  logic             rsp_taken;

  // Ready is combinational from the valids; the pointer only breaks ties.
  assign gnt0    = r0.valid & (~r1.valid | ~rr_q);
  assign gnt1    = r1.valid & (~r0.valid |  rr_q);
  assign in_idle = (state_q == S_IDLE) & reset_n;
  assign r0.ready = in_idle & gnt0;
  assign r1.ready = in_idle & gnt1;
  assign hs       = r0.ready | r1.ready;

  assign sel_aluop = gnt1 ? r1.aluop : r0.aluop;
  assign sel_funct = gnt1 ? r1.funct : r0.funct;

  always_comb begin
    dec_ctl     = 3'b000;
    dec_illegal = 1'b0;
    case (sel_aluop)
      2'b00: dec_ctl = 3'b010;
      2'b01: dec_ctl = 3'b110;
      2'b10: begin
        case (sel_funct)
          6'b100000: dec_ctl = 3'b010;
          6'b100010: dec_ctl = 3'b110;
          6'b100100: dec_ctl = 3'b000;
          6'b100101: dec_ctl = 3'b001;
          6'b000000: dec_ctl = 3'b011;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign rsp_taken = port_q ? r1.rsp_ready : r0.rsp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hs) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      S_RESP:  if (rsp_taken) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rr_q      <= FIRST_PRI;
      port_q    <= 1'b0;
      illegal_q <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctl_q <= 3'b000;
      result_q  <= '0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Operands go straight into the ALU-facing registers, so they hold outside ISSUE.
      if (hs) begin
        port_q    <= gnt1;
        rr_q      <= ~gnt1;
        illegal_q <= dec_illegal;
        alu_a_q   <= gnt1 ? r1.a : r0.a;
        alu_b_q   <= gnt1 ? r1.b : r0.b;
        alu_ctl_q <= dec_illegal ? 3'b000 : dec_ctl;
      end
      if (state_q == S_ISSUE) begin
        result_q <= illegal_q ? '0 : alu_result;
        zero_q   <= illegal_q ? 1'b0 : alu_zero;
        err_q    <= illegal_q;
      end
    end
  end

  assign alu_en  = (state_q == S_ISSUE) & ~illegal_q;
  assign alu_ctl = alu_ctl_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;

  assign r0.rsp_valid  = (state_q == S_RESP) & ~port_q;
  assign r1.rsp_valid  = (state_q == S_RESP) &  port_q;
  assign r0.rsp_result = result_q;
  assign r1.rsp_result = result_q;
  assign r0.rsp_zero   = zero_q;
  assign r1.rsp_zero   = zero_q;
  assign r0.rsp_err    = err_q;
  assign r1.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the shared-ALU service.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_en;
  logic [2:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  alu_share_arbiter_if #(.WIDTH(32)) r0_if ();
  alu_share_arbiter_if #(.WIDTH(32)) r1_if ();

  alu_share_arbiter #(.WIDTH(32), .FIRST_PRI(1'b0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .r0         (r0_if),
    .r1         (r1_if),
    .alu_en     (alu_en),
    .alu_ctl    (alu_ctl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external combinational ALU.
  always_comb begin
    case (alu_ctl)
      3'b010:  alu_result = alu_a + alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b011:  alu_result = alu_a << alu_b[4:0];
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_zero = (alu_result == 32'h0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Operation semantics of each request, from opcode meaning rather than control code.
  function automatic void ref_op(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output bit legal, output logic [2:0] ctl,
                                 output logic [31:0] res);
    legal = 1'b1;
    ctl   = 3'b000;
    res   = 32'h0;
    if (op == 2'd0)      begin ctl = 3'b010; res = a + b; end
    else if (op == 2'd1) begin ctl = 3'b110; res = a - b; end
    else if (op == 2'd2 && fn == 6'h20) begin ctl = 3'b010; res = a + b; end
    else if (op == 2'd2 && fn == 6'h22) begin ctl = 3'b110; res = a - b; end
    else if (op == 2'd2 && fn == 6'h24) begin ctl = 3'b000; res = a & b; end
    else if (op == 2'd2 && fn == 6'h25) begin ctl = 3'b001; res = a | b; end
    else if (op == 2'd2 && fn == 6'h00) begin ctl = 3'b011; res = a << b[4:0]; end
    else legal = 1'b0;
  endfunction

  // Model: idle, or holding one transaction whose age counts cycles since acceptance.
  initial begin
    bit          m_busy, m_rr, m_port, m_legal, m_zero, e0, e1, lg, rdy;
    int          m_age;
    logic [31:0] m_res, m_a, m_b, fa, fb, r;
    logic [2:0]  m_ctl, c;
    logic [1:0]  fop;
    logic [5:0]  ffn;
    m_busy = 0; m_rr = 0; m_port = 0; m_legal = 0; m_zero = 0; m_age = 0;
    m_res = 0; m_a = 0; m_b = 0; m_ctl = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_busy = 0; m_age = 0; m_rr = 0; m_a = 0; m_b = 0; m_ctl = 0;
      end else begin
        chk("r0_rsp_valid", 32'(r0_if.rsp_valid), 32'(m_busy && m_age >= 2 && !m_port));
        chk("r1_rsp_valid", 32'(r1_if.rsp_valid), 32'(m_busy && m_age >= 2 && m_port));
        chk("alu_en", 32'(alu_en), 32'(m_busy && m_age == 1 && m_legal));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_ctl", 32'(alu_ctl), 32'(m_ctl));
        if (!m_busy) begin
          e0 = r0_if.valid && (!r1_if.valid || !m_rr);
          e1 = r1_if.valid && (!r0_if.valid || m_rr);
          chk("r0_ready", 32'(r0_if.ready), 32'(e0));
          chk("r1_ready", 32'(r1_if.ready), 32'(e1));
          if (e0 || e1) begin
            m_port = e1;
            fop = e1 ? r1_if.aluop : r0_if.aluop;
            ffn = e1 ? r1_if.funct : r0_if.funct;
            fa  = e1 ? r1_if.a : r0_if.a;
            fb  = e1 ? r1_if.b : r0_if.b;
            ref_op(fop, ffn, fa, fb, lg, c, r);
            m_legal = lg;
            m_res   = lg ? r : 32'h0;
            m_zero  = lg && (r == 32'h0);
            m_ctl   = lg ? c : 3'b000;
            m_a = fa; m_b = fb;
            m_rr = !e1; m_busy = 1; m_age = 1;
          end
        end else begin
          chk("r0_ready_busy", 32'(r0_if.ready), 32'(0));
          chk("r1_ready_busy", 32'(r1_if.ready), 32'(0));
          if (m_age == 1) begin
            m_age = 2;
          end else begin
            chk("rsp_result", m_port ? r1_if.rsp_result : r0_if.rsp_result, m_res);
            chk("rsp_zero", 32'(m_port ? r1_if.rsp_zero : r0_if.rsp_zero), 32'(m_zero));
            chk("rsp_err", 32'(m_port ? r1_if.rsp_err : r0_if.rsp_err), 32'(!m_legal));
            rdy = m_port ? r1_if.rsp_ready : r0_if.rsp_ready;
            if (rdy) begin
              $display("txn port=%0d result=%h zero=%0b err=%0b", m_port, m_res, m_zero, !m_legal);
              m_busy = 0; m_age = 0;
            end
          end
        end
      end
    end
  end

  task automatic set_req(input bit p, input bit v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
    if (p) begin
      r1_if.valid = v; r1_if.aluop = op; r1_if.funct = fn; r1_if.a = a; r1_if.b = b;
    end else begin
      r0_if.valid = v; r0_if.aluop = op; r0_if.funct = fn; r0_if.a = a; r0_if.b = b;
    end
  endtask

  // Presents one request and withdraws it right after acceptance; returns at posedge+1.
  task automatic issue(input bit p, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    bit got = 0;
    set_req(p, 1'b1, op, fn, a, b);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = p ? r1_if.ready : r0_if.ready;
    end
    if (!got) chk("accept_timeout", 32'(got), 32'(1));
    @(posedge clk); #1;
    if (p) r1_if.valid = 1'b0; else r0_if.valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input bit p, input logic [31:0] res,
                            input bit zero, input bit err, output int lat);
    bit got = 0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = p ? r1_if.rsp_valid : r0_if.rsp_valid;
    end
    chk({tag, "_seen"}, 32'(got), 32'(1));
    chk({tag, "_result"}, p ? r1_if.rsp_result : r0_if.rsp_result, res);
    chk({tag, "_zero"}, 32'(p ? r1_if.rsp_zero : r0_if.rsp_zero), 32'(zero));
    chk({tag, "_err"}, 32'(p ? r1_if.rsp_err : r0_if.rsp_err), 32'(err));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_req(0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    r0_if.rsp_ready = 1'b1;
    r1_if.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_r0_ready"}, 32'(r0_if.ready), 32'(0));
    chk({tag, "_r1_ready"}, 32'(r1_if.ready), 32'(0));
    chk({tag, "_r0_rspv"}, 32'(r0_if.rsp_valid), 32'(0));
    chk({tag, "_r1_rspv"}, 32'(r1_if.rsp_valid), 32'(0));
    chk({tag, "_alu_en"}, 32'(alu_en), 32'(0));
    chk({tag, "_alu_ctl"}, 32'(alu_ctl), 32'(0));
    chk({tag, "_alu_a"}, alu_a, 32'h0);
    chk({tag, "_alu_b"}, alu_b, 32'h0);
    chk({tag, "_result"}, r0_if.rsp_result, 32'h0);
    chk({tag, "_err"}, 32'(r0_if.rsp_err), 32'(0));
  endtask

  initial begin
    int lat, ta, tb;
    bit got, gp;
    logic [5:0] fn_tab [5];
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25; fn_tab[4] = 6'h00;

    // Reset state
    do_reset();
    reset_n = 1'b0;
    #1 chk_reset_outputs("reset");
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: add 5+7 on r0
    issue(0, 2'b00, 6'h00, 32'd5, 32'd7);
    expect_rsp("t1", 0, 32'd12, 1'b0, 1'b0, lat);
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_alu_ctl", 32'(alu_ctl), 32'(3'b010));

    // 2: both valid after reset -> strict alternation starting with r0
    do_reset();
    set_req(0, 1'b1, 2'b01, 6'h00, 32'd9, 32'd9);
    set_req(1, 1'b1, 2'b00, 6'h00, 32'd1, 32'd2);
    for (int k = 0; k < 3; k++) begin
      got = 0; gp = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = r0_if.ready || r1_if.ready;
        gp  = r1_if.ready;
      end
      chk("t2_grant_seen", 32'(got), 32'(1));
      chk("t2_grant_port", 32'(gp), 32'(k % 2));
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 2'b01, 6'h00, 32'd9, 32'd9);
    set_req(1, 1'b0, 2'b00, 6'h00, 32'd1, 32'd2);
    expect_rsp("t2_last", 0, 32'd0, 1'b1, 1'b0, lat);

    // 3: illegal funct on r1
    issue(1, 2'b10, 6'b101010, 32'd3, 32'd4);
    expect_rsp("t3", 1, 32'd0, 1'b0, 1'b1, lat);

    // 4: r0 sll stalled 4 cycles while r1 waits
    r0_if.rsp_ready = 1'b0;
    issue(0, 2'b10, 6'h00, 32'd3, 32'd4);
    set_req(1, 1'b1, 2'b00, 6'h00, 32'd10, 32'd20);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_held_result", r0_if.rsp_result, 32'd48);
    chk("t4_r1_blocked", 32'(r1_if.ready), 32'(0));
    r0_if.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_r1_accept", 32'(r1_if.ready), 32'(1));
    @(posedge clk); #1;
    r1_if.valid = 1'b0;
    expect_rsp("t4_r1", 1, 32'd30, 1'b0, 1'b0, lat);

    // 5: reset during ISSUE
    issue(0, 2'b00, 6'h00, 32'd100, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("t5");
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(0, 2'b00, 6'h00, 32'd1, 32'd2);
    expect_rsp("t5_after", 0, 32'd3, 1'b0, 1'b0, lat);

    // 6: back-to-back and / or on r0
    set_req(0, 1'b1, 2'b10, 6'h24, 32'hff00, 32'h0ff0);
    got = 0; ta = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = r0_if.ready; ta = cyc; end
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'b10, 6'h25, 32'hff00, 32'h00ff);
    got = 0; tb = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = r0_if.ready; tb = cyc; end
    chk("t6_second_accept", 32'(got), 32'(1));
    chk("t6_spacing", 32'(tb - ta), 32'd3);
    @(posedge clk); #1;
    r0_if.valid = 1'b0;
    expect_rsp("t6_or", 0, 32'h0000ffff, 1'b0, 1'b0, lat);

    // Random traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] ra, rb;
        logic [1:0]  op;
        logic [5:0]  fn;
        ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
        rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
        op = 2'($urandom_range(0, 3));
        fn = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
        set_req(p[0], $urandom_range(0, 99) < 60, op, fn, ra, rb);
      end
      r0_if.rsp_ready = $urandom_range(0, 99) < 70;
      r1_if.rsp_ready = $urandom_range(0, 99) < 70;
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    r0_if.rsp_ready = 1'b1;
    r1_if.rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
